// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the execute stage and muldiv_unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             divzero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, divzero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, divzero
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative shift-add multiplier / restoring divider with HI/LO registers
// Signed ops run on magnitudes; signs are reapplied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  state_t state, state_next;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               dvsr_zero;
  logic               done_r;
  logic               divzero_r;

  logic               is_signed;
  logic               md_req;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               fits;
  logic [WIDTH-1:0]   quo;
  logic [2*WIDTH-1:0] prod;

  assign is_signed = bus.op[0];
  assign md_req    = bus.start && !bus.op[2];
  assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply: acc holds {partial product, remaining multiplier bits}; opnd is the multiplicand.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

  // Divide: acc low half shifts dividend bits out and quotient bits in; opnd is the divisor.
  assign shifted = {rem, acc[WIDTH-1]};
  assign fits    = shifted >= {1'b0, opnd};
  assign diff    = shifted[WIDTH-1:0] - opnd;

  assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign prod = neg_res ? -acc : acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (md_req) state_next = ITER;
      ITER:    if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      opnd      <= '0;
      rem       <= '0;
      hi_r      <= '0;
      lo_r      <= '0;
      cnt       <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      dvsr_zero <= 1'b0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (md_req) begin
            is_div    <= bus.op[1];
            neg_res   <= is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem   <= is_signed && bus.a[WIDTH-1];
            dvsr_zero <= (bus.b == '0);
            acc       <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
            opnd      <= bus.op[1] ? b_mag : a_mag;
            rem       <= '0;
            cnt       <= '0;
          end else if (bus.start && bus.op == 3'b100) begin
            hi_r <= bus.a;
          end else if (bus.start && bus.op == 3'b101) begin
            lo_r <= bus.a;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], fits};
            rem            <= fits ? diff : shifted[WIDTH-1:0];
          end else begin
            acc <= {sum, acc[WIDTH-1:1]};
          end
        end
        FIX: begin
          done_r <= 1'b1;
          if (is_div) begin
            // Divide by zero: quotient forced to all ones; remainder path already yields a.
            lo_r      <= dvsr_zero ? {WIDTH{1'b1}} : quo;
            hi_r      <= neg_rem ? -rem : rem;
            divzero_r <= dvsr_zero;
          end else begin
            {hi_r, lo_r} <= prod;
            divzero_r    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_r;
  assign bus.hi      = hi_r;
  assign bus.lo      = lo_r;
  assign bus.divzero = divzero_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (WIDTH=32)
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errs = 0;
  logic [31:0] last_hi, last_lo;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(W)) bus();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0; busy_cycles = 0;
    while (!bus.done && edges < 100) begin
      if (bus.busy) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  // Reference: full-width integer arithmetic, truncating signed division.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sx, sy, q, r;
    logic [63:0] p;
    edz = 1'b0;
    if (o[1] == 1'b0) begin
      if (o[0]) p = 64'(longint'($signed(x)) * longint'($signed(y)));
      else      p = 64'(x) * 64'(y);
      {eh, el} = p;
    end else if (y == 32'd0) begin
      el = 32'hFFFFFFFF; eh = x; edz = 1'b1;
    end else begin
      sx = o[0] ? longint'($signed(x)) : longint'({32'd0, x});
      sy = o[0] ? longint'($signed(y)) : longint'({32'd0, y});
      q = sx / sy;
      r = sx % sy;
      el = q[31:0];
      eh = r[31:0];
    end
  endfunction

  task automatic run_and_check(input string tag, input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                               input logic edz);
    int e, bc;
    issue(o, x, y);
    wait_done(e, bc);
    check({tag, "_latency"}, e, 33);
    check({tag, "_busy_cycles"}, bc, 33);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_hi"}, bus.hi, eh);
    check({tag, "_lo"}, bus.lo, el);
    check({tag, "_divzero"}, bus.divzero, edz);
    last_hi = eh; last_lo = el;
    @(negedge clk);
    check({tag, "_done_width"}, bus.done, 0);
  endtask

  initial begin
    int e, bc, k;
    logic [2:0]  o;
    logic [31:0] x, y, eh, el;
    logic        edz;

    reset_n = 1'b0; bus.start = 1'b0; bus.op = 3'b000; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_divzero", bus.divzero, 0);
    reset_n = 1'b1;
    @(negedge clk);

    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    check("mthi_hi", bus.hi, 32'h1234);
    check("mthi_done", bus.done, 0);
    check("mthi_busy", bus.busy, 0);
    bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo_lo", bus.lo, 32'h5678);
    check("mtlo_hi_kept", bus.hi, 32'h1234);

    bus.start = 1'b1; bus.op = 3'b110; bus.a = 32'hDEAD; bus.b = 32'h3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("noop_busy", bus.busy, 0);
    check("noop_hi", bus.hi, 32'h1234);
    check("noop_lo", bus.lo, 32'h5678);

    vecs[0] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1] = '{3'b001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2] = '{3'b010, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[3] = '{3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{3'b010, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{3'b000, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    vecs[7] = '{3'b011, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[8] = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9] = '{3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    for (int i = 0; i < 10; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].dz);

    // Back-to-back: next start issued in the done cycle.
    issue(3'b000, 32'd6, 32'd7);
    wait_done(e, bc);
    check("b2b_first_lo", bus.lo, 32'd42);
    check("b2b_first_latency", e, 33);
    issue(3'b010, 32'd100, 32'd7);
    wait_done(e, bc);
    check("b2b_second_latency", e, 33);
    check("b2b_second_lo", bus.lo, 32'd14);
    check("b2b_second_hi", bus.hi, 32'd2);
    last_hi = 32'd2; last_lo = 32'd14;
    @(negedge clk);

    // Requests while busy must be dropped, including MTHI.
    issue(3'b001, 32'hFFFFFFFD, 32'd5);
    k = 1;
    while (!bus.done && k < 100) begin
      bus.start = (k == 5 || k == 10 || k == 20);
      bus.op    = (k == 10) ? 3'b100 : 3'b000;
      bus.a     = (k == 10) ? 32'h1234 : $urandom;
      bus.b     = $urandom;
      if (k == 15) begin
        check("busy_hold_hi", bus.hi, last_hi);
        check("busy_hold_lo", bus.lo, last_lo);
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    check("busy_seq_latency", k - 1, 33);
    check("busy_seq_hi", bus.hi, 32'hFFFFFFFF);
    check("busy_seq_lo", bus.lo, 32'hFFFFFFF1);
    @(negedge clk);
    check("busy_seq_no_requeue", bus.busy, 0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 3));
      x = (i % 8 == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 15);
        2:       y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      model(o, x, y, eh, el, edz);
      run_and_check($sformatf("rand%0d_op%0d", i, o), o, x, y, eh, el, edz);
    end

    // Asynchronous reset in the middle of a divide.
    issue(3'b011, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    check("arst_done", bus.done, 0);
    check("arst_divzero", bus.divzero, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    issue(3'b000, 32'd3, 32'd4);
    wait_done(e, bc);
    check("post_rst_latency", e, 33);
    check("post_rst_lo", bus.lo, 32'd12);
    check("post_rst_hi", bus.hi, 32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle combinational MUL path in the ALU with a shift-add multiplier and a restoring divider, and adds signed and unsigned modes, division, and MTHI/MTLO writes. The unit sits beside the ALU in the execute stage. The top level stalls on `busy` before issuing MFHI/MFLO, which read `hi`/`lo` directly.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; legal range is WIDTH >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while busy=0.
- op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x no-op.
- a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- b  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an iterative operation is in flight.
- done  out  1  single-cycle pulse when hi/lo take a mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- divzero  out  1  set at done of a DIV/DIVU with b=0; cleared at done of any other mul/div.

## Operation
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1 with op=MULT/MULTU/DIV/DIVU: latch operand magnitudes and sign flags, clear the counter, go to ITER.
  - start=1 with op=MTHI/MTLO: write `a` into hi/lo at that edge. State stays IDLE; no busy, no done.
  - op=11x: ignored.
- ITER: one bit per cycle for WIDTH cycles.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, partial remainder WIDTH+1 bits.
  - After the WIDTH-th iteration go to FIX.
- FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
- Unsigned ops: operands are taken as-is.
- Signed ops: operands are converted to magnitude at accept. Sign corrections:
  - Product sign = sa^sb; the full 2*WIDTH result is negated.
  - Quotient sign = sa^sb.
  - Remainder sign = sa (truncating division).
- Results: MUL gives {hi,lo} = product. DIV gives lo = quotient, hi = remainder.
- Divide by zero (either signedness): lo = all ones, hi = a as latched, divzero=1. Latency is unchanged.
- Signed overflow (DIV with a = most negative value, b = -1): lo = most negative value, hi = 0. This is the natural result of the magnitude path and needs no special case.
- start while busy=1: ignored for all ops, including MTHI/MTLO. Operands are not re-sampled.
- hi/lo keep their previous values throughout ITER/FIX until the FIX edge.

## Timing
- Reset (reset_n=0, takes effect immediately, not clock-gated): state=IDLE, busy=0, done=0, divzero=0, hi=0, lo=0, counter=0, internal datapath registers=0.
- Reset mid-operation: the operation is aborted and no done is produced. A start in the first cycle after release is accepted normally.
- Accept edge E0: busy=1 from the cycle after E0.
- Iterations: edges E1..E_WIDTH.
- FIX edge E_(WIDTH+1): hi/lo/divzero update; done=1 and busy=0 for the following cycle.
- Latency: WIDTH+1 cycles from accept to result (33 for WIDTH=32).
- Back-to-back: start may be asserted in the done cycle, because busy=0 there. It is accepted at the next edge.
- MTHI/MTLO: hi/lo are visible the cycle after the accept edge.
- done is never high for more than one cycle.

## Test plan
All scenarios use WIDTH=32.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 cycles after accept; busy high for 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Divide:
  - DIVU 7/2 -> lo=3, hi=1.
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, divzero=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, divzero=1. A following MULTU 2*3 -> lo=6, hi=0, divzero=0.
- Busy-time requests:
  - Pulse start with new operands at cycles 5 and 20 of a MULT -> ignored; the original result is intact.
  - MTHI 0x1234 while busy -> ignored.
  - MTHI 0x1234 while idle -> hi=0x1234 next cycle, done stays 0.
- Assert reset_n=0 asynchronously at cycle 10 of a DIV -> hi=lo=0 and busy=0 immediately, no done pulse. After release, MULTU 3*4 -> lo=12 after 33 cycles.
